// File: rtl/approx_mul_pkg.sv
// Shared definitions for the quadrant-split approximate multiplier: quadrant
// indices, the mode vector type and the approximate quadrant product function.
package approx_mul_pkg;

  localparam int QLL = 0;
  localparam int QLH = 1;
  localparam int QHL = 2;
  localparam int QHH = 3;

  // Widest half-operand the shared product function supports.
  localparam int MAX_H = 32;

  typedef logic [3:0] mode_t;

  // Exact product with the low t result bits replaced by (x | y) when approx is set.
  function automatic logic [2*MAX_H-1:0] approx_quad_prod(
    input logic [MAX_H-1:0] x,
    input logic [MAX_H-1:0] y,
    input int               t,
    input logic             approx
  );
    logic [2*MAX_H-1:0] p;
    p = (2*MAX_H)'(x) * (2*MAX_H)'(y);
    if (approx) begin
      for (int i = 0; i < MAX_H; i++) begin
        if (i < t) p[i] = x[i] | y[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/approx_quad.sv
// One half-width quadrant multiplier, exact or approximate per beat.
module approx_quad
  import approx_mul_pkg::*;
#(
  parameter int H = 4,
  parameter int T = 2
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx,
  output logic [2*H-1:0] q
);

  assign q = (2*H)'(approx_quad_prod(MAX_H'(x), MAX_H'(y), T, approx));

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage valid/ready approximate multiplier with saturating recombination
// and a wrap-around accumulator; S1 holds quadrant products, S2 the results.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int W     = 8,
  parameter int T     = 2,
  parameter int ACC_W = 2*W + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  mode_t            in_mode,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_prod,
  output logic [ACC_W-1:0] out_acc
);

  localparam int H  = W / 2;
  localparam int PW = 2 * W;

  function automatic logic [PW-1:0] sat_prod(input logic [PW:0] s);
    return s[PW] ? '1 : s[PW-1:0];
  endfunction

  logic [3:0][2*H-1:0] q_c;
  logic [3:0][2*H-1:0] q_p1;
  logic                acc_en_p1;
  logic                vld_p1;
  logic [PW-1:0]       prod_p2;
  logic [ACC_W-1:0]    acc_p2;
  logic                vld_p2;
  logic                s1_adv;
  logic                s2_adv;
  logic [PW:0]         sum_c;
  logic [PW-1:0]       prod_c;
  logic [ACC_W-1:0]    acc_c;

  approx_quad #(.H(H), .T(T)) u_ll (.x(in_a[H-1:0]), .y(in_b[H-1:0]), .approx(in_mode[QLL]), .q(q_c[QLL]));
  approx_quad #(.H(H), .T(T)) u_lh (.x(in_a[H-1:0]), .y(in_b[W-1:H]), .approx(in_mode[QLH]), .q(q_c[QLH]));
  approx_quad #(.H(H), .T(T)) u_hl (.x(in_a[W-1:H]), .y(in_b[H-1:0]), .approx(in_mode[QHL]), .q(q_c[QHL]));
  approx_quad #(.H(H), .T(T)) u_hh (.x(in_a[W-1:H]), .y(in_b[W-1:H]), .approx(in_mode[QHH]), .q(q_c[QHH]));

  assign s2_adv   = !vld_p2 | out_ready;
  assign s1_adv   = vld_p1 & s2_adv;
  assign in_ready = !vld_p1 | s1_adv;

  // ---- stage 1: quadrant products and accumulate flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      q_p1      <= '0;
      acc_en_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        q_p1      <= q_c;
        acc_en_p1 <= in_acc;
      end
    end
  end

  always_comb begin
    sum_c  = ((PW+1)'(q_p1[QHH]) << W)
           + (((PW+1)'(q_p1[QHL]) + (PW+1)'(q_p1[QLH])) << H)
           + (PW+1)'(q_p1[QLL]);
    prod_c = sat_prod(sum_c);
    acc_c  = acc_en_p1 ? (acc_p2 + ACC_W'(prod_c)) : ACC_W'(prod_c);
  end

  // ---- stage 2: output register; acc_p2 is the accumulator itself ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      prod_p2 <= '0;
      acc_p2  <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        prod_p2 <= prod_c;
        acc_p2  <= acc_c;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_prod  = prod_p2;
  assign out_acc   = acc_p2;

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Parametrised, pipelined successor to the fixed 8x8 quadrant-split approximate multiplier. It splits each W-bit operand into high and low halves and forms four half-width quadrant products. Each quadrant is independently exact or approximate, selected per beat. The block adds a valid/ready pipeline with backpressure, saturating recombination and an optional wrap-around accumulator, and sits between operand producers and error-tolerant datapath consumers (filters, MAC arrays).

## Interface
- W, default 8: operand width; must be even and at least 4; H = W/2.
- T, default 2: truncated low result bits per approximate quadrant; 0 ≤ T ≤ H.
- ACC_W, default 2W+8: accumulator width; must be at least 2W.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  W  unsigned operand A.
- in_b  in  W  unsigned operand B.
- in_mode  in  4  per-quadrant approximation enable, 1 = approximate. Bit 0 = al·bl, bit 1 = al·bh, bit 2 = ah·bl, bit 3 = ah·bh.
- in_acc  in  1  1 = add the product to the accumulator; 0 = load the accumulator with the product.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_prod  out  2W  saturated product.
- out_acc  out  ACC_W  accumulator value including this beat.

## Operation
- Exact quadrant product: q = x·y, 2H bits.
- Approximate quadrant product:
  - Compute the exact product x·y.
  - Replace result bits [T-1:0] with (x[T-1:0] | y[T-1:0]).
  - When T = 0 this equals the exact product.
- Recombination:
  - sum = (hh << W) + ((hl + lh) << H) + ll, computed at 2W+1 bits.
  - If sum ≥ 2^(2W), then out_prod = 2^(2W) − 1 (saturate); otherwise out_prod = sum.
  - With all four mode bits = 0, out_prod is always the exact product and never saturates.
- Accumulator:
  - Register acc of ACC_W bits.
  - When a beat moves from S1 to S2: acc ← (in_acc ? acc + prod : prod), modulo 2^ACC_W (wrap, no saturation).
  - out_acc carries the updated acc.
  - in_acc is captured with the beat in S1.
- Ordering: beats leave in acceptance order; nothing is dropped or duplicated.

## Timing
- Two register stages:
  - S1 holds the four quadrant products and the in_acc flag.
  - S2 is the output register holding out_prod and out_acc.
- Latency: an input accepted in cycle n gives out_valid in cycle n+2 when there is no stall.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - S2 advances when !out_valid | out_ready.
  - S1 advances into S2 when S1 is valid and S2 advances.
  - in_ready = !s1_valid | s1_advances; this is combinational from out_ready and has no combinational path from in_valid.
- Full throughput is one beat per cycle with out_ready held high. With out_ready low, at most 2 beats are held and in_ready goes low.
- out_prod and out_acc hold stable while out_valid & !out_ready.
- Simultaneous input accept and output drain in the same cycle: both transfers occur and no bubble is inserted.
- Reset values: in_ready = 1 after reset release, out_valid = 0, out_prod = 0, out_acc = 0, acc = 0, S1 valid = 0.
- Reset mid-operation: all in-flight beats are discarded and the accumulator is cleared immediately (asynchronous).

## Structure
- Package approx_mul_pkg:
  - Quadrant index constants QLL = 0, QLH = 1, QHL = 2, QHH = 3.
  - Mode typedef: 4-bit mode vector.
  - Function computing the approximate quadrant product, shared by the RTL and the bench model.
- Sub-module approx_quad:
  - Ports: H-bit x, H-bit y, approximation enable; parameter T; output 2H-bit product.
  - Instantiated four times.
- Top level holds the S1/S2 registers, handshake logic, recombination, saturation and the accumulator.

## Test plan
- Exact product: W=8, T=2, in_a=0xFF, in_b=0xFF, in_mode=0 → out_prod=0xFE01 two cycles after accept.
- Approximate product: in_a=0x12, in_b=0x34, in_mode=0xF → quadrants hh=3, hl=5, lh=7, ll=10, out_prod=0x03CA (exact value is 0x03A8).
- Saturation: in_a=0xFF, in_b=0xFF, in_mode=0xE → raw sum 0x10041, out_prod=0xFFFF.
- Accumulate: beats (3,4,acc=0) then (5,6,acc=1), in_mode=0 → out_acc=12, then 42. With ACC_W=16, two beats 0xFF·0xFF (acc=0, then acc=1) → out_acc=0xFE01, then 0xFC02.
- Backpressure: hold out_ready low and offer 4 back-to-back beats.
  - Required: only 2 beats accepted and in_ready deasserts.
  - Required: outputs stable while stalled.
  - Required: on out_ready high, all 4 beats emerge in order with correct values.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight and a nonzero acc.
  - Required: out_valid=0 and out_acc=0 immediately.
  - Required: the first post-reset beat with in_acc=1 yields out_acc equal to its own product.
